// File: rtl/decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// decode_pipe_stage
//
// Registered RV32I decode stage between fetch and execute. The incoming
// instruction is decoded combinationally and the decoded entry is registered,
// so an accepted instruction shows up on the outputs one cycle later.
//
// SKID_EN=1 keeps two entries (output register plus skid register). in_ready
// then depends only on registered state, so there is no combinational path
// from out_ready to in_ready. SKID_EN=0 keeps a single register and lets
// in_ready follow out_ready combinationally.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready        fetch-side handshake; in_instr, in_pc are the payload
//   flush                    drops every held entry and any input accepted this cycle
//   out_valid/out_ready      execute-side handshake
//   out_pc, out_imm          PC and sign-extended immediate of the entry
//   out_alu, out_ctrl        ALU code (alu_codes_t) and 10-bit control word
//   out_btype, out_funct3    branch type (branch_type_t) and instr[14:12]
//   out_rs1/rs2/rd           register indices
//   out_illegal              entry holds an illegal instruction
// ---------------------------------------------------------------------------

package decode_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SLL  = 4'h1,
        ALU_SLT  = 4'h2,
        ALU_SLTU = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SRL  = 4'h5,
        ALU_OR   = 4'h6,
        ALU_AND  = 4'h7,
        ALU_SUB  = 4'h8,
        ALU_SRA  = 4'hD,
        ALU_NOP  = 4'hF
    } alu_codes_t;

    typedef enum logic [1:0] {
        NON_TYPE         = 2'b00,
        JAL_TYPE         = 2'b01,
        JALR_TYPE        = 2'b10,
        CONDITIONAL_TYPE = 2'b11
    } branch_type_t;

    // Major opcodes, instr[6:2].
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    // Control words.
    localparam logic [9:0] CTRL_LUI    = 10'h040;
    localparam logic [9:0] CTRL_AUIPC  = 10'h05E;
    localparam logic [9:0] CTRL_OPIMM  = 10'h04E;
    localparam logic [9:0] CTRL_OP     = 10'h046;
    localparam logic [9:0] CTRL_LOAD   = 10'h06F;
    localparam logic [9:0] CTRL_STORE  = 10'h08E;
    localparam logic [9:0] CTRL_JAL    = 10'h042;
    localparam logic [9:0] CTRL_JALR   = 10'h04A;
    localparam logic [9:0] CTRL_BRANCH = 10'h000;

endpackage

module decode_pipe_stage
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_W    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu,
    output logic [9:0]      out_ctrl,
    output logic [1:0]      out_btype,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu;
        logic [9:0]      ctrl;
        logic [1:0]      btype;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{
        pc: '0, imm: '0, alu: ALU_NOP, ctrl: '0, btype: NON_TYPE,
        funct3: '0, rs1: '0, rs2: '0, rd: '0, illegal: 1'b0
    };

    state_t state_q, state_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    entry_t dec;

    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm32;
    logic        illegal;
    logic        shift_f7_zero;
    logic        shift_f7_arith;
    logic        accept;
    logic        consume;

    // ------------------------------------------------------------------
    // Combinational decode of the instruction offered on the input side.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        opcode  = in_instr[6:2];
        funct3  = in_instr[14:12];
        funct7  = in_instr[31:25];
        imm32   = '0;
        illegal = 1'b0;

        // RV64 shifts use a 6-bit shamt, so the funct7 check loses bit 25.
        if (XLEN == 64) begin
            shift_f7_zero  = (in_instr[31:26] == 6'b000000);
            shift_f7_arith = (in_instr[31:26] == 6'b010000);
        end else begin
            shift_f7_zero  = (funct7 == 7'b0000000);
            shift_f7_arith = (funct7 == 7'b0100000);
        end

        dec         = ENTRY_RST;
        dec.pc      = in_pc;
        dec.funct3  = funct3;
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.rd      = in_instr[11:7];
        dec.alu     = ALU_ADD;
        dec.btype   = NON_TYPE;

        case (opcode)
            OPC_LUI: begin
                dec.ctrl = CTRL_LUI;
                imm32    = {in_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec.ctrl = CTRL_AUIPC;
                imm32    = {in_instr[31:12], 12'b0};
            end
            OPC_OPIMM: begin
                dec.ctrl = CTRL_OPIMM;
                imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
                // Only SRAI carries instr[30] into the ALU code; for the other
                // immediate ops bit 30 is just part of the immediate.
                dec.alu  = {in_instr[30] && (funct3 == 3'b101), funct3};
                if (funct3 == 3'b001 && !shift_f7_zero)
                    illegal = 1'b1;
                if (funct3 == 3'b101 && !(shift_f7_zero || shift_f7_arith))
                    illegal = 1'b1;
            end
            OPC_OP: begin
                dec.ctrl = CTRL_OP;
                dec.alu  = {in_instr[30], funct3};
                if (funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    illegal = 1'b1;
                else if (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101)
                    illegal = 1'b1;
            end
            OPC_LOAD: begin
                dec.ctrl = CTRL_LOAD;
                imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_STORE: begin
                dec.ctrl = CTRL_STORE;
                imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_JAL: begin
                dec.ctrl  = CTRL_JAL;
                dec.btype = JAL_TYPE;
                imm32     = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                dec.ctrl  = CTRL_JALR;
                dec.btype = JALR_TYPE;
                imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_BRANCH: begin
                dec.ctrl  = CTRL_BRANCH;
                dec.btype = CONDITIONAL_TYPE;
                dec.alu   = ALU_SUB;
                imm32     = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
                if (funct3 == 3'b010 || funct3 == 3'b011)
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        if (in_instr[1:0] != 2'b11)
            illegal = 1'b1;

        dec.imm = XLEN'($signed(imm32));

        // Illegal entries still travel through the pipe but carry no
        // control effects; the register fields are passed through as-is.
        if (illegal) begin
            dec.ctrl  = '0;
            dec.alu   = ALU_NOP;
            dec.btype = NON_TYPE;
            dec.imm   = '0;
        end
        dec.illegal = illegal;
    end

    // ------------------------------------------------------------------
    // Handshake and occupancy control.
    // ------------------------------------------------------------------
    assign out_valid = (state_q != ST_EMPTY);
    assign consume   = out_valid && out_ready;

    // During a flush the input is accepted and thrown away, so fetch never
    // stalls on a redirect.
    assign in_ready  = flush || (SKID_EN ? (state_q != ST_SKID)
                                         : ((state_q == ST_EMPTY) || out_ready));
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = ST_EMPTY;
            skid_d  = ENTRY_RST;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        out_d   = dec;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        out_d = dec;
                    end else if (accept) begin
                        // Only reachable with SKID_EN=1: the single-register
                        // variant deasserts in_ready while stalled.
                        state_d = ST_SKID;
                        skid_d  = dec;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (consume) begin
                        state_d = ST_FULL;
                        out_d   = skid_q;
                        skid_d  = ENTRY_RST;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its _d value from before this edge, independent of order.
        if (rst) begin
            state_q <= ST_EMPTY;
            out_q   <= ENTRY_RST;
            skid_q  <= ENTRY_RST;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign out_pc      = out_q.pc;
    assign out_imm     = out_q.imm;
    assign out_alu     = out_q.alu;
    assign out_ctrl    = out_q.ctrl;
    assign out_btype   = out_q.btype;
    assign out_funct3  = out_q.funct3;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_pipe_stage
//
// Directed bench for decode_pipe_stage. Instance dut uses the skid buffer,
// instance dut0 the single-register variant. Inputs change 1 time unit after
// a rising edge; outputs are sampled at the same point, well clear of the edge.
// ---------------------------------------------------------------------------
module tb_decode_pipe_stage;

    localparam int XLEN = 32;
    localparam int PC_W = 32;

    // ALU / branch-type encodings used in expected values.
    localparam logic [3:0] A_ADD = 4'h0;
    localparam logic [3:0] A_SUB = 4'h8;
    localparam logic [3:0] A_SRA = 4'hD;
    localparam logic [3:0] A_NOP = 4'hF;
    localparam logic [1:0] B_NON = 2'b00;
    localparam logic [1:0] B_JAL = 2'b01;
    localparam logic [1:0] B_CND = 2'b11;

    logic            clk = 1'b0;
    logic            rst = 1'b1;

    // Skid-buffer instance.
    logic            in_valid = 1'b0, in_ready, flush = 1'b0;
    logic [31:0]     in_instr = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic            out_valid, out_ready = 1'b0, out_illegal;
    logic [PC_W-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [3:0]      out_alu;
    logic [9:0]      out_ctrl;
    logic [1:0]      out_btype;
    logic [2:0]      out_funct3;
    logic [4:0]      out_rs1, out_rs2, out_rd;

    // Single-register instance.
    logic            in_valid0 = 1'b0, in_ready0, flush0 = 1'b0;
    logic [31:0]     in_instr0 = '0;
    logic [PC_W-1:0] in_pc0 = '0;
    logic            out_valid0, out_ready0 = 1'b0, out_illegal0;
    logic [PC_W-1:0] out_pc0;
    logic [XLEN-1:0] out_imm0;
    logic [3:0]      out_alu0;
    logic [9:0]      out_ctrl0;
    logic [1:0]      out_btype0;
    logic [2:0]      out_funct30;
    logic [4:0]      out_rs10, out_rs20, out_rd0;

    int checks   = 0;
    int failures = 0;

    decode_pipe_stage #(.XLEN(XLEN), .PC_W(PC_W), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_alu(out_alu), .out_ctrl(out_ctrl), .out_btype(out_btype),
        .out_funct3(out_funct3), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_illegal(out_illegal)
    );

    decode_pipe_stage #(.XLEN(XLEN), .PC_W(PC_W), .SKID_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_instr(in_instr0), .in_pc(in_pc0),
        .flush(flush0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_pc(out_pc0), .out_imm(out_imm0),
        .out_alu(out_alu0), .out_ctrl(out_ctrl0), .out_btype(out_btype0),
        .out_funct3(out_funct30), .out_rs1(out_rs10), .out_rs2(out_rs20), .out_rd(out_rd0),
        .out_illegal(out_illegal0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [PC_W-1:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic check_dec(input string tag, input logic [3:0] alu, input logic [9:0] ctrl,
                             input logic [31:0] imm, input logic [1:0] btype, input logic ill);
        check({tag, ".valid"},   64'(out_valid),   64'(1'b1));
        check({tag, ".alu"},     64'(out_alu),     64'(alu));
        check({tag, ".ctrl"},    64'(out_ctrl),    64'(ctrl));
        check({tag, ".imm"},     64'(out_imm),     64'(imm));
        check({tag, ".btype"},   64'(out_btype),   64'(btype));
        check({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 64'(out_valid), 64'(1'b0));
        check("rst.alu",   64'(out_alu),   64'(A_NOP));
        check("rst.imm",   64'(out_imm),   64'(0));
        check("rst.ctrl",  64'(out_ctrl),  64'(0));
        check("rst.pc",    64'(out_pc),    64'(0));
        rst = 1'b0;
        #1;
        check("rst.in_ready", 64'(in_ready), 64'(1'b1));

        // ---------------- decode, streaming with out_ready=1 ----------------
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'h0000_1000);             // addi x1,x0,-1
        tick();
        check_dec("addi", A_ADD, 10'h04E, 32'hFFFF_FFFF, B_NON, 1'b0);
        check("addi.rd", 64'(out_rd), 64'(1));
        check("addi.pc", 64'(out_pc), 64'(32'h0000_1000));

        drive(1'b1, 32'h4030D093, 32'h0000_1004);             // srai x1,x1,3
        tick();
        check_dec("srai", A_SRA, 10'h04E, 32'h0000_0403, B_NON, 1'b0);
        check("srai.rs1", 64'(out_rs1), 64'(1));

        drive(1'b1, 32'h40208133, 32'h0000_1008);             // sub x2,x1,x2
        tick();
        check_dec("sub", A_SUB, 10'h046, 32'h0, B_NON, 1'b0);
        check("sub.rd",  64'(out_rd),  64'(2));
        check("sub.rs2", 64'(out_rs2), 64'(2));

        drive(1'b1, 32'h4020C133, 32'h0000_100C);             // xor with funct7=0x20
        tick();
        check_dec("xor_f7", A_NOP, 10'h000, 32'h0, B_NON, 1'b1);

        drive(1'b1, 32'hFE000EE3, 32'h0000_1010);             // beq x0,x0,-4
        tick();
        check_dec("beq", A_SUB, 10'h000, 32'hFFFF_FFFC, B_CND, 1'b0);
        check("beq.funct3", 64'(out_funct3), 64'(0));

        drive(1'b1, 32'hFE002EE3, 32'h0000_1014);             // branch funct3=010
        tick();
        check_dec("br_f3_010", A_NOP, 10'h000, 32'h0, B_NON, 1'b1);

        drive(1'b1, 32'h12345037, 32'h0000_1018);             // lui x0,0x12345
        tick();
        check_dec("lui", A_ADD, 10'h040, 32'h1234_5000, B_NON, 1'b0);

        drive(1'b1, 32'h0080006F, 32'h0000_101C);             // jal x0,+8
        tick();
        check_dec("jal", A_ADD, 10'h042, 32'h0000_0008, B_JAL, 1'b0);

        drive(1'b1, 32'h00000010, 32'h0000_1020);             // instr[1:0]=00
        tick();
        check_dec("lowbits", A_NOP, 10'h000, 32'h0, B_NON, 1'b1);

        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("drain.valid", 64'(out_valid), 64'(1'b0));

        // ---------------- back-pressure with skid buffer ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h0000_0100);
        tick();
        check("skid.c1.pc",    64'(out_pc),   64'(32'h100));
        check("skid.c1.ready", 64'(in_ready), 64'(1'b1));
        drive(1'b1, 32'hFFF00093, 32'h0000_0104);
        tick();
        check("skid.c2.pc",    64'(out_pc),   64'(32'h100));
        check("skid.c2.ready", 64'(in_ready), 64'(1'b0));
        drive(1'b1, 32'hFFF00093, 32'h0000_0108);
        tick();
        check("skid.c3.pc",    64'(out_pc),    64'(32'h100));
        check("skid.c3.valid", 64'(out_valid), 64'(1'b1));
        check("skid.c3.ready", 64'(in_ready),  64'(1'b0));
        out_ready = 1'b1;
        tick();
        check("skid.o2.pc",    64'(out_pc),   64'(32'h104));
        check("skid.o2.ready", 64'(in_ready), 64'(1'b1));
        tick();
        check("skid.o3.pc",    64'(out_pc),    64'(32'h108));
        check("skid.o3.valid", 64'(out_valid), 64'(1'b1));
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("skid.empty", 64'(out_valid), 64'(1'b0));

        // ---------------- flush from the SKID state ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h0000_0200);
        tick();
        drive(1'b1, 32'hFFF00093, 32'h0000_0204);
        tick();
        check("flush.pre_ready", 64'(in_ready), 64'(1'b0));
        flush = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'h0000_0208);
        #1;
        check("flush.in_ready", 64'(in_ready), 64'(1'b1));
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("flush.valid", 64'(out_valid), 64'(1'b0));
        check("flush.ready", 64'(in_ready),  64'(1'b1));
        out_ready = 1'b1;
        tick();
        check("flush.stays_empty", 64'(out_valid), 64'(1'b0));

        // ---------------- back-pressure without skid buffer ----------------
        in_valid0 = 1'b1; in_instr0 = 32'hFFF00093; in_pc0 = 32'h0000_0300;
        #1;
        check("noskid.ready0", 64'(in_ready0), 64'(1'b1));
        tick();
        check("noskid.c1.pc",    64'(out_pc0),   64'(32'h300));
        check("noskid.c1.ready", 64'(in_ready0), 64'(1'b0));
        in_pc0 = 32'h0000_0304;
        tick();
        check("noskid.c2.pc", 64'(out_pc0), 64'(32'h300));
        tick();
        check("noskid.c3.pc",    64'(out_pc0),    64'(32'h300));
        check("noskid.c3.valid", 64'(out_valid0), 64'(1'b1));
        out_ready0 = 1'b1;
        #1;
        check("noskid.comb_ready", 64'(in_ready0), 64'(1'b1));
        tick();
        check("noskid.o2.pc", 64'(out_pc0), 64'(32'h304));
        in_valid0 = 1'b0;
        tick();
        check("noskid.empty", 64'(out_valid0), 64'(1'b0));

        // ---------------- asynchronous reset mid-stream ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'h40208133, 32'h0000_0400);
        tick();
        check("arst.pre_valid", 64'(out_valid), 64'(1'b1));
        check("arst.pre_alu",   64'(out_alu),   64'(A_SUB));
        #2;
        rst = 1'b1;
        #1;
        check("arst.valid", 64'(out_valid), 64'(1'b0));
        check("arst.alu",   64'(out_alu),   64'(A_NOP));
        check("arst.pc",    64'(out_pc),    64'(0));
        drive(1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("arst.in_ready", 64'(in_ready), 64'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
